// File: rtl/score_keeper_pkg.sv
// Shared game-state codes, item codes and frightened-mode types for the score keeper.
package score_keeper_pkg;

    localparam logic [3:0] GS_IDLE      = 4'd0;
    localparam logic [3:0] GS_READY     = 4'd1;
    localparam logic [3:0] GS_PLAY      = 4'd2;
    localparam logic [3:0] GS_DYING     = 4'd3;
    localparam logic [3:0] GS_LEVEL_END = 4'd4;
    localparam logic [3:0] GS_GAME_OVER = 4'd5;

    localparam logic [1:0] I_NONE      = 2'd0;
    localparam logic [1:0] I_DOT       = 2'd1;
    localparam logic [1:0] I_ENERGIZER = 2'd2;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_FRIGHT,
        FS_FLASH
    } fright_state_t;

    localparam int          SCORE_W        = 20;
    localparam logic [19:0] SCORE_MAX      = 20'hFFFFF;
    localparam logic [11:0] PTS_DOT        = 12'd10;
    localparam logic [11:0] PTS_ENERGIZER  = 12'd50;
    localparam logic [11:0] PTS_GHOST_BASE = 12'd200;
    localparam logic [2:0]  LIVES_MAX      = 3'd7;

    // 200 / 400 / 800 / 1600 for combo 0..3
    function automatic logic [11:0] ghost_points(input logic [1:0] combo);
        return PTS_GHOST_BASE << combo;
    endfunction

endpackage

// File: rtl/score_keeper_fright_timer.sv
// Frightened-mode sequencer: a down-counting timer with a flashing tail.
// state     | meaning
// FS_IDLE   | ghosts normal, timer parked at 0
// FS_FRIGHT | ghosts frightened, timer above the flash threshold
// FS_FLASH  | ghosts frightened and flashing, timer counting out the tail
module fright_timer
    import score_keeper_pkg::*;
#(
    parameter logic [23:0] FRIGHT_CYCLES = 24'd6_000_000,
    parameter logic [23:0] FLASH_CYCLES  = 24'd1_500_000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    input  logic start_i,
    input  logic force_idle_i,
    output logic frightened_o,
    output logic flash_o
);

    fright_state_t state_q, state_d;
    logic [23:0]   timer_q, timer_d;
    logic [23:0]   timer_dec;

    assign timer_dec = (timer_q == 24'd0) ? 24'd0 : timer_q - 24'd1;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= FS_IDLE;
            timer_q <= 24'd0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (force_idle_i) begin
            state_d = FS_IDLE;
            timer_d = 24'd0;
        end else if (en_i) begin
            if (start_i) begin
                state_d = FS_FRIGHT;
                timer_d = FRIGHT_CYCLES;
            end else begin
                case (state_q)
                    FS_FRIGHT: begin
                        timer_d = timer_dec;
                        // zero check first so a zero-length tail skips FLASH entirely
                        if (timer_dec == 24'd0) begin
                            state_d = FS_IDLE;
                        end else if (timer_dec == FLASH_CYCLES) begin
                            state_d = FS_FLASH;
                        end
                    end
                    FS_FLASH: begin
                        timer_d = timer_dec;
                        if (timer_dec == 24'd0) begin
                            state_d = FS_IDLE;
                        end
                    end
                    default: begin
                        state_d = FS_IDLE;
                        timer_d = 24'd0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        frightened_o = (state_q != FS_IDLE);
        flash_o      = (state_q == FS_FLASH);
    end

endmodule

// File: rtl/score_keeper.sv
// Score, lives and dot bookkeeping for one player, with tile-clear requests
// and the frightened-ghost combo scoring.
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int unsigned DOTS_TOTAL       = 244,
    parameter logic [23:0] FRIGHT_CYCLES    = 24'd6_000_000,
    parameter logic [23:0] FLASH_CYCLES     = 24'd1_500_000,
    parameter int unsigned START_LIVES      = 3,
    parameter int unsigned EXTRA_LIFE_SCORE = 10000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [3:0]  i_game_state,
    input  logic        i_item_eaten,
    input  logic [1:0]  i_item_eaten_type,
    input  logic [5:0]  i_item_eaten_x,
    input  logic [5:0]  i_item_eaten_y,
    input  logic        i_pacman_eaten,
    input  logic [3:0]  i_ghost_eaten,
    output logic        o_item_clear,
    output logic [5:0]  o_item_clear_x,
    output logic [5:0]  o_item_clear_y,
    output logic [19:0] o_score,
    output logic [7:0]  o_dots_left,
    output logic [2:0]  o_lives,
    output logic        o_frightened,
    output logic        o_flash,
    output logic        o_level_clear,
    output logic        o_game_over
);

    logic        play, level_load, item_valid, coord_new, accept, energizer_acc;
    logic [3:0]  ghost_rise;
    logic        pacman_rise, pacman_hit, fright_kill;
    logic        frightened, flash;
    logic [11:0] item_pts;
    logic [12:0] ghost_pts;
    logic [1:0]  combo_v;
    logic [21:0] score_sum;
    logic        extra_grant;

    logic [19:0] score_q, score_d;
    logic [7:0]  dots_q, dots_d;
    logic [2:0]  lives_q, lives_d;
    logic [1:0]  combo_q, combo_d;
    logic        extra_q, extra_d;
    logic        last_valid_q, last_valid_d;
    logic [5:0]  last_x_q, last_x_d, last_y_q, last_y_d;
    logic        clear_q, clear_d;
    logic [5:0]  clear_x_q, clear_x_d, clear_y_q, clear_y_d;
    logic        level_clear_q, level_clear_d;
    logic        game_over_q, game_over_d;
    logic [3:0]  gs_q;
    logic [3:0]  ghost_prev_q;
    logic        pacman_prev_q;

    assign play        = (i_game_state == GS_PLAY);
    assign level_load  = (gs_q == GS_LEVEL_END) && (i_game_state == GS_READY);
    assign item_valid  = (i_item_eaten_type == I_DOT) || (i_item_eaten_type == I_ENERGIZER);
    // the map holds i_item_eaten high until the tile clears, so repeats are dropped
    assign coord_new   = !last_valid_q || (i_item_eaten_x != last_x_q) || (i_item_eaten_y != last_y_q);
    assign accept      = play && i_item_eaten && item_valid && coord_new;
    assign energizer_acc = accept && (i_item_eaten_type == I_ENERGIZER);
    assign ghost_rise  = i_ghost_eaten & ~ghost_prev_q;
    assign pacman_rise = i_pacman_eaten & ~pacman_prev_q;
    assign pacman_hit  = play && pacman_rise;
    assign fright_kill = level_load || pacman_hit;

    fright_timer #(
        .FRIGHT_CYCLES(FRIGHT_CYCLES),
        .FLASH_CYCLES (FLASH_CYCLES)
    ) u_fright_timer (
        .clk_i        (i_clk),
        .rst_n_i      (i_rst_n),
        .en_i         (play),
        .start_i      (energizer_acc),
        .force_idle_i (fright_kill),
        .frightened_o (frightened),
        .flash_o      (flash)
    );

    always_comb begin
        item_pts = 12'd0;
        if (accept) begin
            item_pts = (i_item_eaten_type == I_ENERGIZER) ? PTS_ENERGIZER : PTS_DOT;
        end
    end

    // blinky (bit 0) is scored first, each ghost doubling the next one's value
    always_comb begin
        ghost_pts = 13'd0;
        combo_v   = combo_q;
        if (play && frightened) begin
            for (int g = 0; g < 4; g++) begin
                if (ghost_rise[g]) begin
                    ghost_pts = ghost_pts + {1'b0, ghost_points(combo_v)};
                    if (combo_v != 2'd3) begin
                        combo_v = combo_v + 2'd1;
                    end
                end
            end
        end
        combo_d = energizer_acc ? 2'd0 : combo_v;
    end

    always_comb begin
        score_sum = {2'b00, score_q} + {10'd0, item_pts} + {9'd0, ghost_pts};
        score_d   = (score_sum > {2'b00, SCORE_MAX}) ? SCORE_MAX : score_sum[19:0];
    end

    assign extra_grant = !extra_q
                         && ({12'd0, score_q} <  EXTRA_LIFE_SCORE)
                         && ({12'd0, score_d} >= EXTRA_LIFE_SCORE);
    assign extra_d     = extra_q | extra_grant;

    always_comb begin
        lives_d = lives_q;
        if (pacman_hit && (lives_q != 3'd0)) begin
            lives_d = lives_d - 3'd1;
        end
        if (extra_grant && (lives_d != LIVES_MAX)) begin
            lives_d = lives_d + 3'd1;
        end
    end

    always_comb begin
        dots_d       = dots_q;
        last_valid_d = last_valid_q;
        last_x_d     = last_x_q;
        last_y_d     = last_y_q;
        clear_d      = accept;
        clear_x_d    = clear_x_q;
        clear_y_d    = clear_y_q;
        if (level_load) begin
            dots_d       = 8'(DOTS_TOTAL);
            last_valid_d = 1'b0;
        end else if (accept) begin
            if (dots_q != 8'd0) begin
                dots_d = dots_q - 8'd1;
            end
            last_valid_d = 1'b1;
            last_x_d     = i_item_eaten_x;
            last_y_d     = i_item_eaten_y;
            clear_x_d    = i_item_eaten_x;
            clear_y_d    = i_item_eaten_y;
        end
        level_clear_d = (dots_q == 8'd0);
        game_over_d   = (lives_q == 3'd0);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            score_q       <= 20'd0;
            dots_q        <= 8'(DOTS_TOTAL);
            lives_q       <= 3'(START_LIVES);
            combo_q       <= 2'd0;
            extra_q       <= 1'b0;
            last_valid_q  <= 1'b0;
            last_x_q      <= 6'd0;
            last_y_q      <= 6'd0;
            clear_q       <= 1'b0;
            clear_x_q     <= 6'd0;
            clear_y_q     <= 6'd0;
            level_clear_q <= 1'b0;
            game_over_q   <= 1'b0;
            gs_q          <= GS_IDLE;
            ghost_prev_q  <= 4'd0;
            pacman_prev_q <= 1'b0;
        end else begin
            score_q       <= score_d;
            dots_q        <= dots_d;
            lives_q       <= lives_d;
            combo_q       <= combo_d;
            extra_q       <= extra_d;
            last_valid_q  <= last_valid_d;
            last_x_q      <= last_x_d;
            last_y_q      <= last_y_d;
            clear_q       <= clear_d;
            clear_x_q     <= clear_x_d;
            clear_y_q     <= clear_y_d;
            level_clear_q <= level_clear_d;
            game_over_q   <= game_over_d;
            gs_q          <= i_game_state;
            ghost_prev_q  <= i_ghost_eaten;
            pacman_prev_q <= i_pacman_eaten;
        end
    end

    assign o_item_clear   = clear_q;
    assign o_item_clear_x = clear_x_q;
    assign o_item_clear_y = clear_y_q;
    assign o_score        = score_q;
    assign o_dots_left    = dots_q;
    assign o_lives        = lives_q;
    assign o_frightened   = frightened;
    assign o_flash        = flash;
    assign o_level_clear  = level_clear_q;
    assign o_game_over    = game_over_q;

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 SHALL have parameters: DOTS_TOTAL, default 244, number of collectibles (dots and energizers) per level; FRIGHT_CYCLES, default 24'd6_000_000, frightened duration in clocks; FLASH_CYCLES, default 24'd1_500_000, flashing tail within the frightened period; START_LIVES, default 3; EXTRA_LIFE_SCORE, default 10000.
REQ-002 SHALL have ports, clock and reset first: i_clk in 1, system clock; i_rst_n in 1, asynchronous active-low reset; i_game_state in 4, game FSM state; i_item_eaten in 1, item under pacman; i_item_eaten_type in 2, I_DOT/I_ENERGIZER/I_NONE; i_item_eaten_x in 6, tile x; i_item_eaten_y in 6, tile y; i_pacman_eaten in 1, pacman collided with a non-frightened ghost; i_ghost_eaten in 4, frightened ghost collided, one bit per ghost {clyde, inky, pinky, blinky}.
REQ-003 SHALL have outputs: o_item_clear out 1, one-cycle request to clear a tile; o_item_clear_x out 6; o_item_clear_y out 6; o_score out 20, binary score; o_dots_left out 8; o_lives out 3; o_frightened out 1; o_flash out 1; o_level_clear out 1; o_game_over out 1.

Function
REQ-004 SHALL update only when i_game_state == GS_PLAY; in any other state, all counters and the frightened FSM hold, and o_item_clear stays 0.
REQ-005 SHALL accept an item event when i_item_eaten=1 and (x,y) differs from the last accepted coordinate, or no coordinate has been accepted since reset or level load; an identical repeat coordinate SHALL be ignored because the input is level-held until the map clears.
REQ-006 SHALL, on the clock edge after acceptance, pulse o_item_clear for exactly 1 cycle with the accepted x,y (1-cycle latency).
REQ-007 SHALL add 10 for I_DOT and 50 for I_ENERGIZER, and decrement o_dots_left by 1 for either type, saturating at 0.
REQ-008 SHALL saturate the score at 20'hFFFFF and never wrap.
REQ-009 SHALL implement the frightened FSM: IDLE -> FRIGHT on energizer acceptance, loading the timer with FRIGHT_CYCLES; FRIGHT -> FLASH when timer == FLASH_CYCLES; FLASH -> IDLE when timer reaches 0.
REQ-010 SHALL reload the timer and re-enter FRIGHT on any energizer accepted in FRIGHT or FLASH, and reset the ghost combo to 0.
REQ-011 SHALL drive o_frightened=1 in FRIGHT and FLASH, and o_flash=1 in FLASH only.
REQ-012 SHALL score each rising bit of i_ghost_eaten, only while frightened, at 200<<combo (200/400/800/1600), with combo incrementing per ghost and saturating at 3; simultaneous bits SHALL be scored in order blinky, pinky, inky, clyde within one cycle, summed.
REQ-013 SHALL decrement lives on the rising edge of i_pacman_eaten, saturating at 0, and force the frightened FSM to IDLE in the same cycle; ghost scoring in that cycle still applies.
REQ-014 SHALL add one life, up to a maximum of 7, the first time the score crosses EXTRA_LIFE_SCORE; this grant occurs at most once until reset.
REQ-015 SHALL make o_level_clear=1 registered when o_dots_left==0, and o_game_over=1 registered when o_lives==0.
REQ-016 SHALL, on a transition into GS_READY from GS_LEVEL_END, reload o_dots_left=DOTS_TOTAL, clear the last-coordinate register, and force the FSM to IDLE; score and lives are retained.

Reset
REQ-017 SHALL on i_rst_n=0, asynchronously and at any time including mid-frightened: score=0, dots_left=DOTS_TOTAL, lives=START_LIVES, FSM=IDLE, timer=0, combo=0, extra-life flag=0, last-coordinate valid=0, and all pulse outputs 0.

Structure
REQ-018 SHALL take GS_* states, I_* item codes, and a fright_state_t enum {FS_IDLE, FS_FRIGHT, FS_FLASH} from the shared params package.
REQ-019 SHALL place the frightened FSM and timer in one sub-module, fright_timer.

Verification
REQ-020 SHALL cover: GS_PLAY, I_DOT at (5,3) held for 4 cycles -> one o_item_clear at (5,3), score 10, dots_left 243.
REQ-021 SHALL cover: energizer accepted, then 4 ghost bits one per cycle -> score +50+200+400+800+1600=3050, o_flash rises FRIGHT_CYCLES-FLASH_CYCLES cycles after acceptance.
REQ-022 SHALL cover: i_ghost_eaten=4'b1111 in a single cycle while frightened -> +3000 in that one cycle.
REQ-023 SHALL cover: score preloaded at 9990 plus one dot -> score 10000 and lives 4; a second crossing grants nothing.
REQ-024 SHALL cover: reset asserted during FLASH -> o_frightened=0 immediately, score 0, lives 3.
REQ-025 SHALL cover: with lives=1, an i_pacman_eaten pulse -> lives 0 and o_game_over=1 next cycle; a held i_pacman_eaten decrements only once.
